wt_ptr_gen: RTL and testbench



---
 rtl/fifo_pkg.sv | 45 ++++
 rtl/ptr_sync.sv | 46 ++++
 rtl/wt_ptr_gen.sv | 109 ++++++++++
 tb/tb_wt_ptr_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the asynchronous FIFO pointer logic (write side and
// read side).
//   ADDR_WIDTH_DEF : default address width; FIFO depth is 2**ADDR_WIDTH_DEF
//   ptr_t          : pointer type (ADDR_WIDTH_DEF+1 bits, MSB is the lap bit)
//   code_t         : wide container the Gray helpers work on
//   bin2gray()     : binary -> Gray, result limited to the low 'width' bits
//   gray2bin()     : Gray -> binary, input limited to the low 'width' bits
// Callers zero-extend their pointer into code_t and cast the result back to
// their own width. This keeps one function usable for any pointer width.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 4;
    localparam int unsigned CODE_W         = 32;

    typedef logic [ADDR_WIDTH_DEF:0] ptr_t;
    typedef logic [CODE_W-1:0]       code_t;

    // Mask keeping the low 'width' bits. Pointer widths are far below CODE_W.
    function automatic code_t width_mask(input int unsigned width);
        return (code_t'(1) << width) - code_t'(1);
    endfunction

    function automatic code_t bin2gray(input code_t bin, input int unsigned width);
        code_t b;
        b = bin & width_mask(width);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it. Bits above
    // 'width' are cleared first, so they contribute nothing.
    function automatic code_t gray2bin(input code_t gray, input int unsigned width);
        code_t g;
        code_t b;
        g = gray & width_mask(width);
        b[CODE_W-1] = g[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// -----------------------------------------------------------------------------
// ptr_sync
// N-stage flop chain that carries a Gray pointer into another clock domain.
// There is no logic between stages, which keeps metastability resolution time
// intact. The read side reuses this block for the write pointer.
//   i_clk : destination-domain clock
//   i_rst : synchronous, active-high reset; clears every stage
//   i_d   : Gray pointer from the source domain (asynchronous)
//   o_q   : synchronized Gray pointer, from the last stage
// Parameters: width (pointer width), stages (chain depth, must be >= 2).
// -----------------------------------------------------------------------------
module ptr_sync #(
    parameter int width  = 5,
    parameter int stages = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [width-1:0] i_d,
    output logic [width-1:0] o_q
);

    logic [width-1:0] r_sync [stages];

    // NOTE: sequential state is written only with non-blocking assignments, so
    // each stage samples the value its neighbour held before the edge. With
    // blocking assignments the chain would collapse into a single flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: this register array is reset stage by stage on purpose. A
            // stale pointer left in the chain would show up as a false read
            // position after reset. Arrays that hold plain storage should not
            // be reset this way.
            for (int i = 0; i < stages; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < stages; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[stages-1];

endmodule

// File: rtl/wt_ptr_gen.sv
// -----------------------------------------------------------------------------
// wt_ptr_gen
// Write-domain pointer generator for the asynchronous FIFO. It accepts pushes
// that are not blocked by full and advances the binary write pointer. It
// publishes the Gray write pointer to the read domain and brings the read
// domain's Gray pointer back as a binary pointer.
//   wt_clk       : write-domain clock
//   wt_rst       : synchronous, active-high reset
//   push         : write request from the producer
//   full         : from the status generator
//   rd_gray_in   : Gray read pointer from the read domain (asynchronous)
//   wt_addr      : registered binary write pointer (addr_width+1 bits)
//   wt_gray_out  : registered Gray write pointer for the read domain
//   rd_addr_sync : binary read pointer, synchronized into this domain
//   mem_wt_en    : memory write strobe (accepted push)
//   mem_wt_addr  : memory write address (pointer without its lap bit)
//   wt_count     : registered occupancy as seen from the write side
//   push_drop    : registered pulse, set for one cycle when a push hits full
// Full is pessimistic because rd_addr_sync lags the reader. A push can be
// refused for up to sync_stages cycles after space frees up. Unread data is
// never overwritten.
// -----------------------------------------------------------------------------
module wt_ptr_gen
    import fifo_pkg::*;
#(
    parameter int addr_width  = ADDR_WIDTH_DEF,
    parameter int sync_stages = 2
) (
    input  logic                  wt_clk,
    input  logic                  wt_rst,
    input  logic                  push,
    input  logic                  full,
    input  logic [addr_width:0]   rd_gray_in,
    output logic [addr_width:0]   wt_addr,
    output logic [addr_width:0]   wt_gray_out,
    output logic [addr_width:0]   rd_addr_sync,
    output logic                  mem_wt_en,
    output logic [addr_width-1:0] mem_wt_addr,
    output logic [addr_width:0]   wt_count,
    output logic                  push_drop
);

    localparam int PTR_W = addr_width + 1;

    typedef logic [PTR_W-1:0] wptr_t;

    wptr_t r_wt_addr;
    wptr_t r_wt_gray;
    wptr_t r_wt_count;
    logic  r_push_drop;

    logic  w_acc;
    wptr_t w_wt_addr_next;
    wptr_t w_wt_gray_next;
    wptr_t w_rd_gray_sync;
    wptr_t w_rd_addr_sync;

    // Reset wins over push. mem_wt_en is held low while reset is asserted,
    // so a push that coincides with reset never reaches the memory.
    assign w_acc = push & ~full & ~wt_rst;

    // NOTE: all next-state logic is continuous assignment. Each signal has
    // exactly one full-cover driver, so no latch can be inferred. Any later
    // always_comb block must assign a default to every output first.
    assign w_wt_addr_next = r_wt_addr + wptr_t'(w_acc);

    // The Gray pointer is registered from the next binary value, not from the
    // current one. It then changes on the same edge as wt_addr, flips exactly
    // one bit per increment, and comes straight from a flop (no glitches
    // across the clock crossing).
    assign w_wt_gray_next = wptr_t'(bin2gray(code_t'(w_wt_addr_next), PTR_W));

    ptr_sync #(
        .width  (PTR_W),
        .stages (sync_stages)
    ) u_rd_sync (
        .i_clk (wt_clk),
        .i_rst (wt_rst),
        .i_d   (rd_gray_in),
        .o_q   (w_rd_gray_sync)
    );

    assign w_rd_addr_sync = wptr_t'(gray2bin(code_t'(w_rd_gray_sync), PTR_W));

    always_ff @(posedge wt_clk) begin
        if (wt_rst) begin
            r_wt_addr   <= '0;
            r_wt_gray   <= '0;
            r_wt_count  <= '0;
            r_push_drop <= 1'b0;
        end else begin
            r_wt_addr   <= w_wt_addr_next;
            r_wt_gray   <= w_wt_gray_next;
            // Modular subtraction: the lap bit makes 0..2**addr_width
            // unambiguous even after the pointers wrap.
            r_wt_count  <= w_wt_addr_next - w_rd_addr_sync;
            r_push_drop <= push & full;
        end
    end

    assign wt_addr      = r_wt_addr;
    assign wt_gray_out  = r_wt_gray;
    assign rd_addr_sync = w_rd_addr_sync;
    assign wt_count     = r_wt_count;
    assign push_drop    = r_push_drop;
    assign mem_wt_en    = w_acc;
    assign mem_wt_addr  = r_wt_addr[addr_width-1:0];

endmodule

// File: tb/tb_wt_ptr_gen.sv
// -----------------------------------------------------------------------------
// tb_wt_ptr_gen
// Directed bench for wt_ptr_gen. The main instance uses sync_stages=2, and
// full comes from a small status-generator model. A second instance uses
// sync_stages=3 and only exercises the read-pointer latency.
// -----------------------------------------------------------------------------
module tb_wt_ptr_gen;

    logic       clk;
    logic       wt_rst;
    logic       push;
    logic       full;
    logic [4:0] rd_gray_in;
    logic [4:0] wt_addr;
    logic [4:0] wt_gray_out;
    logic [4:0] rd_addr_sync;
    logic       mem_wt_en;
    logic [3:0] mem_wt_addr;
    logic [4:0] wt_count;
    logic       push_drop;

    logic       push3;
    logic       full3;
    logic [4:0] rd_gray3;
    logic [4:0] wt_addr3;
    logic [4:0] wt_gray3;
    logic [4:0] rd_addr_sync3;
    logic       mem_wt_en3;
    logic [3:0] mem_wt_addr3;
    logic [4:0] wt_count3;
    logic       push_drop3;

    int total = 0;
    int bad   = 0;

    // Status-generator model: full when the pointers differ only in the lap bit.
    assign full = ((wt_addr ^ rd_addr_sync) == 5'b10000);

    wt_ptr_gen #(.addr_width(4), .sync_stages(2)) dut (
        .wt_clk       (clk),
        .wt_rst       (wt_rst),
        .push         (push),
        .full         (full),
        .rd_gray_in   (rd_gray_in),
        .wt_addr      (wt_addr),
        .wt_gray_out  (wt_gray_out),
        .rd_addr_sync (rd_addr_sync),
        .mem_wt_en    (mem_wt_en),
        .mem_wt_addr  (mem_wt_addr),
        .wt_count     (wt_count),
        .push_drop    (push_drop)
    );

    wt_ptr_gen #(.addr_width(4), .sync_stages(3)) dut3 (
        .wt_clk       (clk),
        .wt_rst       (wt_rst),
        .push         (push3),
        .full         (full3),
        .rd_gray_in   (rd_gray3),
        .wt_addr      (wt_addr3),
        .wt_gray_out  (wt_gray3),
        .rd_addr_sync (rd_addr_sync3),
        .mem_wt_en    (mem_wt_en3),
        .mem_wt_addr  (mem_wt_addr3),
        .wt_count     (wt_count3),
        .push_drop    (push_drop3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] exp_addr;
        logic [4:0] exp_gray;
        logic [4:0] prev_gray;

        wt_rst     = 1'b1;
        push       = 1'b1;
        rd_gray_in = 5'd0;
        push3      = 1'b0;
        full3      = 1'b0;
        rd_gray3   = 5'd0;

        // Reset state, with push held high to show that mem_wt_en is forced low.
        tick();
        tick();
        check("rst_mem_wt_en", 32'(mem_wt_en), 0);
        check("rst_wt_addr", 32'(wt_addr), 0);
        check("rst_wt_gray", 32'(wt_gray_out), 0);
        check("rst_rd_sync", 32'(rd_addr_sync), 0);
        check("rst_wt_count", 32'(wt_count), 0);
        check("rst_push_drop", 32'(push_drop), 0);
        wt_rst = 1'b0;
        push   = 1'b0;
        tick();

        // Sixteen pushes fill the FIFO.
        for (int i = 0; i < 16; i++) begin
            push = 1'b1;
            #1;
            check("fill_mem_addr", 32'(mem_wt_addr), 32'(i));
            check("fill_mem_en", 32'(mem_wt_en), 1);
            tick();
            exp_addr = 5'(i + 1);
            exp_gray = exp_addr ^ (exp_addr >> 1);
            check("fill_wt_addr", 32'(wt_addr), 32'(exp_addr));
            check("fill_wt_gray", 32'(wt_gray_out), 32'(exp_gray));
            check("fill_wt_count", 32'(wt_count), 32'(exp_addr));
        end
        push = 1'b0;
        check("fill_gray_end", 32'(wt_gray_out), 32'b11000);
        check("fill_full", 32'(full), 1);

        // A push while full is dropped.
        push = 1'b1;
        #1;
        check("drop_mem_en", 32'(mem_wt_en), 0);
        tick();
        push = 1'b0;
        check("drop_pulse", 32'(push_drop), 1);
        check("drop_wt_addr", 32'(wt_addr), 16);
        check("drop_wt_gray", 32'(wt_gray_out), 32'b11000);
        check("drop_wt_count", 32'(wt_count), 16);
        tick();
        check("drop_pulse_end", 32'(push_drop), 0);

        // The reader frees three entries: gray(3) = 00010.
        rd_gray_in = 5'b00010;
        tick();
        check("rel_sync_e1", 32'(rd_addr_sync), 0);
        check("rel_full_e1", 32'(full), 1);
        tick();
        check("rel_sync_e2", 32'(rd_addr_sync), 3);
        check("rel_full_e2", 32'(full), 0);
        tick();
        check("rel_count", 32'(wt_count), 13);
        push = 1'b1;
        #1;
        check("rel_mem_en", 32'(mem_wt_en), 1);
        check("rel_mem_addr", 32'(mem_wt_addr), 0);
        tick();
        push = 1'b0;
        check("rel_wt_addr", 32'(wt_addr), 17);
        check("rel_count2", 32'(wt_count), 14);

        // Let the reader catch up, then push past the wrap with rd_gray_in tracking.
        rd_gray_in = wt_gray_out;
        tick();
        tick();
        tick();
        check("trk_count", 32'(wt_count), 0);
        exp_addr = 5'd17;
        for (int i = 0; i < 56; i++) begin
            push = 1'b1;
            prev_gray = wt_gray_out;
            #1;
            check("wrap_mem_en", 32'(mem_wt_en), 1);
            tick();
            rd_gray_in = wt_gray_out;
            exp_addr = exp_addr + 5'd1;
            check("wrap_wt_addr", 32'(wt_addr), 32'(exp_addr));
            check("wrap_gray_1bit", 32'($countones(prev_gray ^ wt_gray_out)), 1);
            if (exp_addr == 5'd0) begin
                check("wrap_gray_prev", 32'(prev_gray), 32'b10000);
                check("wrap_gray_zero", 32'(wt_gray_out), 0);
                check("wrap_mem_addr", 32'(mem_wt_addr), 0);
            end
        end

        // Reset mid-stream with wt_addr = 9 and push still high.
        check("mid_pre_addr", 32'(wt_addr), 9);
        wt_rst = 1'b1;
        #1;
        check("mid_mem_en_rst", 32'(mem_wt_en), 0);
        tick();
        check("mid_wt_addr", 32'(wt_addr), 0);
        check("mid_wt_gray", 32'(wt_gray_out), 0);
        check("mid_rd_sync", 32'(rd_addr_sync), 0);
        check("mid_wt_count", 32'(wt_count), 0);
        check("mid_push_drop", 32'(push_drop), 0);
        check("mid_mem_en", 32'(mem_wt_en), 0);
        check("mid_mem_addr", 32'(mem_wt_addr), 0);
        wt_rst     = 1'b0;
        rd_gray_in = 5'd0;
        #1;
        check("post_mem_en", 32'(mem_wt_en), 1);
        check("post_mem_addr", 32'(mem_wt_addr), 0);
        tick();
        push = 1'b0;
        check("post_wt_addr", 32'(wt_addr), 1);

        // Three-stage synchronizer: gray(3) appears after three edges.
        rd_gray3 = 5'b00010;
        tick();
        check("s3_sync_e1", 32'(rd_addr_sync3), 0);
        tick();
        check("s3_sync_e2", 32'(rd_addr_sync3), 0);
        tick();
        check("s3_sync_e3", 32'(rd_addr_sync3), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
